// File: rtl/egr_wadj_csr_mc_if.sv
// Avalon-MM style CSR bus between a host master and the egress width-adapter CSR block.
interface egr_wadj_csr_mc_if;
    logic [7:0]  address;
    logic        write;
    logic        read;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        readdatavalid;

    modport master (
        output address, write, read, writedata, byteenable,
        input  readdata, readdatavalid
    );

    modport slave (
        input  address, write, read, writedata, byteenable,
        output readdata, readdatavalid
    );
endinterface

// File: rtl/egr_wadj_csr_mc.sv
// CSR block for the multi-channel egress width adapter: scratch, per-channel drop enable/threshold.
// Drop counters, STATUS, IRQ_MASK and drop_irq exist only when EGR_WADJ_CSR_DROP_CNT_EN is defined.
module egr_wadj_csr_mc #(
    parameter int          NUM_CH     = 4,
    parameter int          CNT_W      = 32,
    parameter logic [15:0] THRESH_RST = 16'h01F0
) (
    input  logic                   clk,
    input  logic                   reset_n,
    egr_wadj_csr_mc_if.slave       bus,
    input  logic [NUM_CH-1:0]      drop_pulse,
    output logic [NUM_CH-1:0]      drop_en,
    output logic [16*NUM_CH-1:0]   drop_threshold,
    output logic                   drop_irq
);

    logic [31:0]                 scratch;
    logic [NUM_CH-1:0][15:0]     thresh;
    logic                        scratch_hit;
    logic [NUM_CH-1:0]           ctrl_hit;
    logic [NUM_CH-1:0]           thr_hit;
    logic [NUM_CH-1:0]           cnt_hit;
    logic [31:0]                 rd_mux;

    assign drop_threshold = thresh;
    assign scratch_hit    = (bus.address == 8'h00);

    // Channel n lives in the 16-byte window starting at 0x10 + 0x10*n.
    always_comb begin
        ctrl_hit = '0;
        thr_hit  = '0;
        cnt_hit  = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            if (bus.address[7:4] == 4'(n + 1)) begin
                ctrl_hit[n] = (bus.address[3:0] == 4'h0);
                thr_hit[n]  = (bus.address[3:0] == 4'h4);
                cnt_hit[n]  = (bus.address[3:0] == 4'h8);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            scratch <= '0;
            drop_en <= '0;
            for (int n = 0; n < NUM_CH; n++) thresh[n] <= THRESH_RST;
        end else if (bus.write) begin
            if (scratch_hit) begin
                for (int b = 0; b < 4; b++)
                    if (bus.byteenable[b]) scratch[8*b +: 8] <= bus.writedata[8*b +: 8];
            end
            for (int n = 0; n < NUM_CH; n++) begin
                if (ctrl_hit[n] && bus.byteenable[0]) drop_en[n] <= bus.writedata[0];
                if (thr_hit[n] && bus.byteenable[0]) thresh[n][7:0]  <= bus.writedata[7:0];
                if (thr_hit[n] && bus.byteenable[1]) thresh[n][15:8] <= bus.writedata[15:8];
            end
        end
    end

`ifdef EGR_WADJ_CSR_DROP_CNT_EN
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [NUM_CH-1:0]            status;
    logic [NUM_CH-1:0]            irq_mask;
    logic [NUM_CH-1:0][CNT_W-1:0] cnt;
    logic [NUM_CH-1:0]            inc;
    logic [NUM_CH-1:0]            rd_clr;
    logic [NUM_CH-1:0]            sat_set;
    logic [NUM_CH-1:0]            status_clr;

    // A clearing read takes priority over saturation; the coincident pulse restarts the count at 1.
    always_comb begin
        inc        = '0;
        rd_clr     = '0;
        sat_set    = '0;
        status_clr = '0;
        for (int n = 0; n < NUM_CH; n++) begin
            inc[n]        = drop_pulse[n] & drop_en[n];
            rd_clr[n]     = bus.read & cnt_hit[n];
            sat_set[n]    = inc[n] & ~rd_clr[n] & (cnt[n] == (CNT_MAX - CNT_ONE));
            status_clr[n] = bus.write & (bus.address == 8'h04) & bus.byteenable[n/8]
                            & bus.writedata[n];
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt      <= '0;
            status   <= '0;
            irq_mask <= '0;
            drop_irq <= 1'b0;
        end else begin
            for (int n = 0; n < NUM_CH; n++) begin
                if (bus.write && bus.address == 8'h08 && bus.byteenable[n/8])
                    irq_mask[n] <= bus.writedata[n];
                if (rd_clr[n])
                    cnt[n] <= inc[n] ? CNT_ONE : '0;
                else if (inc[n] && cnt[n] != CNT_MAX)
                    cnt[n] <= cnt[n] + CNT_ONE;
                if (sat_set[n])
                    status[n] <= 1'b1;
                else if (status_clr[n])
                    status[n] <= 1'b0;
            end
            drop_irq <= |(status & irq_mask);
        end
    end
`else
    logic unused_cnt_inputs;
    assign unused_cnt_inputs = ^{drop_pulse, cnt_hit};
    assign drop_irq = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        if (scratch_hit) rd_mux = scratch;
`ifdef EGR_WADJ_CSR_DROP_CNT_EN
        if (bus.address == 8'h04) rd_mux = 32'(status);
        if (bus.address == 8'h08) rd_mux = 32'(irq_mask);
        for (int n = 0; n < NUM_CH; n++)
            if (cnt_hit[n]) rd_mux = 32'(cnt[n]);
`endif
        for (int n = 0; n < NUM_CH; n++) begin
            if (ctrl_hit[n]) rd_mux = {31'b0, drop_en[n]};
            if (thr_hit[n])  rd_mux = {16'b0, thresh[n]};
        end
    end

    // Read data reflects pre-write state of the accepted cycle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bus.readdata      <= '0;
            bus.readdatavalid <= 1'b0;
        end else begin
            bus.readdatavalid <= bus.read;
            if (bus.read) bus.readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_egr_wadj_csr_mc.sv
// Self-checking bench for egr_wadj_csr_mc: directed scenarios plus random traffic vs. a reference model.
module tb_egr_wadj_csr_mc;
    localparam int NCH     = 4;
    localparam int CW      = 8;
    localparam int CNT_TOP = (1 << CW) - 1;
`ifdef EGR_WADJ_CSR_DROP_CNT_EN
    localparam bit HAS_CNT = 1'b1;
`else
    localparam bit HAS_CNT = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [NCH-1:0]  drop_pulse = '0;
    logic [NCH-1:0]  drop_en;
    logic [16*NCH-1:0] drop_threshold;
    logic            drop_irq;

    egr_wadj_csr_mc_if bus();

    egr_wadj_csr_mc #(.NUM_CH(NCH), .CNT_W(CW), .THRESH_RST(16'h01F0)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .bus            (bus),
        .drop_pulse     (drop_pulse),
        .drop_en        (drop_en),
        .drop_threshold (drop_threshold),
        .drop_irq       (drop_irq)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference state
    logic [31:0]    m_scratch;
    logic [NCH-1:0] m_en;
    logic [15:0]    m_thr [NCH];
    int             m_cnt [NCH];
    logic [NCH-1:0] m_status;
    logic [NCH-1:0] m_mask;
    logic [31:0]    last_rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] thr_flat();
        logic [63:0] f = '0;
        for (int n = 0; n < NCH; n++) f[16*n +: 16] = m_thr[n];
        return f;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] be);
        logic [31:0] r = old;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_read(input logic [7:0] a);
        int ch, off;
        if (a == 8'h00) return m_scratch;
        if (a == 8'h04) return HAS_CNT ? 32'(m_status) : 32'h0;
        if (a == 8'h08) return HAS_CNT ? 32'(m_mask) : 32'h0;
        if (int'(a) >= 16 && int'(a) < 16 + 16 * NCH) begin
            ch  = int'(a) / 16 - 1;
            off = int'(a) % 16;
            if (off == 0) return 32'(m_en[ch]);
            if (off == 4) return 32'(m_thr[ch]);
            if (off == 8) return HAS_CNT ? 32'(m_cnt[ch]) : 32'h0;
        end
        return 32'h0;
    endfunction

    task automatic model_reset();
        m_scratch = '0; m_en = '0; m_status = '0; m_mask = '0;
        for (int n = 0; n < NCH; n++) begin m_thr[n] = 16'h01F0; m_cnt[n] = 0; end
    endtask

    task automatic model_step(input bit rd, input bit wr, input logic [7:0] a,
                              input logic [31:0] wd, input logic [3:0] be, input logic [NCH-1:0] p);
        logic [NCH-1:0] en_pre = m_en;
        logic [NCH-1:0] set_ev = '0;
        int ch, off;
        ch  = int'(a) / 16 - 1;
        off = int'(a) % 16;
        if (wr) begin
            if (a == 8'h00) m_scratch = merge(m_scratch, wd, be);
            if (HAS_CNT && a == 8'h08 && be[0]) m_mask = wd[NCH-1:0];
            if (HAS_CNT && a == 8'h04 && be[0]) m_status = m_status & ~wd[NCH-1:0];
            if (ch >= 0 && ch < NCH && off == 0 && be[0]) m_en[ch] = wd[0];
            if (ch >= 0 && ch < NCH && off == 4) m_thr[ch] = merge(32'(m_thr[ch]), wd, be) & 32'hFFFF;
        end
        if (HAS_CNT) begin
            for (int n = 0; n < NCH; n++) begin
                bit hit = p[n] && en_pre[n];
                if (rd && int'(a) == 16 * (n + 1) + 8) m_cnt[n] = hit ? 1 : 0;
                else if (hit && m_cnt[n] < CNT_TOP) begin
                    m_cnt[n]++;
                    if (m_cnt[n] == CNT_TOP) set_ev[n] = 1'b1;
                end
            end
            m_status = m_status | set_ev;
        end
    endtask

    task automatic step(input bit rd, input bit wr, input logic [7:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic [NCH-1:0] p);
        logic [31:0] exp_rd;
        logic        exp_irq;
        bus.address = a; bus.read = rd; bus.write = wr;
        bus.writedata = wd; bus.byteenable = be; drop_pulse = p;
        exp_rd  = model_read(a);
        exp_irq = HAS_CNT ? |(m_status & m_mask) : 1'b0;
        model_step(rd, wr, a, wd, be, p);
        @(posedge clk); #1;
        bus.read = 1'b0; bus.write = 1'b0; drop_pulse = '0;
        chk("readdatavalid", 64'(bus.readdatavalid), 64'(rd));
        if (rd) chk($sformatf("readdata@%02h", a), 64'(bus.readdata), 64'(exp_rd));
        chk("drop_irq", 64'(drop_irq), 64'(exp_irq));
        chk("drop_en", 64'(drop_en), 64'(m_en));
        chk("drop_threshold", 64'(drop_threshold), thr_flat());
        last_rd = exp_rd;
    endtask

    task automatic rd(input logic [7:0] a);
        step(1'b1, 1'b0, a, 32'h0, 4'h0, '0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        step(1'b0, 1'b1, a, d, be, '0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clk); #1;
        bus.read = 1'b1; bus.address = 8'h14;
        @(posedge clk); #1;
        bus.read = 1'b0;
        model_reset();
        chk("rst_readdatavalid", 64'(bus.readdatavalid), 64'h0);
        chk("rst_readdata", 64'(bus.readdata), 64'h0);
        chk("rst_drop_irq", 64'(drop_irq), 64'h0);
        chk("rst_drop_en", 64'(drop_en), 64'h0);
        chk("rst_threshold", 64'(drop_threshold), 64'h01F0_01F0_01F0_01F0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_readdatavalid", 64'(bus.readdatavalid), 64'h0);
    endtask

    logic [7:0] addr_tbl [14] = '{8'h00, 8'h04, 8'h08, 8'h10, 8'h14, 8'h18, 8'h20, 8'h28,
                                  8'h34, 8'h38, 8'h40, 8'h48, 8'hF0, 8'h0C};

    initial begin
        bus.address = '0; bus.read = 1'b0; bus.write = 1'b0;
        bus.writedata = '0; bus.byteenable = '0;
        model_reset();
        last_rd = '0;

        do_reset();

        // Reset value of ch0 threshold, one-cycle read latency
        rd(8'h14);
        chk("ch0_thr_const", 64'(last_rd), 64'h1F0);

        // Partial byte write to ch1 threshold
        wr(8'h24, 32'h0000ABCD, 4'b0001);
        rd(8'h24);
        chk("ch1_thr_const", 64'(last_rd), 64'h1CD);
        chk("ch1_thr_port", 64'(drop_threshold[31:16]), 64'h01CD);

        // Scratch byte lanes, read+write same cycle returns old value
        wr(8'h00, 32'h12345678, 4'b1111);
        wr(8'h00, 32'hAABBCCDD, 4'b1010);
        step(1'b1, 1'b1, 8'h00, 32'hFFFFFFFF, 4'b0001, '0);
        chk("scratch_prewrite", 64'(last_rd), 64'hAA34CC78);
        rd(8'h00);

        // Channel 2 counts five pulses, read clears
        wr(8'h30, 32'h1, 4'b0001);
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 4'b0100);
        rd(8'h38);
        chk("ch2_cnt5", 64'(last_rd), HAS_CNT ? 64'd5 : 64'd0);
        rd(8'h38);
        chk("ch2_cnt_cleared", 64'(last_rd), 64'd0);

        // Channel 0 saturates, STATUS and IRQ, W1C
        wr(8'h10, 32'h1, 4'b0001);
        for (int i = 0; i < 300; i++) step(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 4'b0001);
        rd(8'h18);
        chk("ch0_sat", 64'(last_rd), HAS_CNT ? 64'hFF : 64'h0);
        rd(8'h04);
        chk("status_sat", 64'(last_rd), HAS_CNT ? 64'h1 : 64'h0);
        wr(8'h08, 32'h1, 4'b0001);
        step(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, '0);
        chk("irq_set", 64'(drop_irq), HAS_CNT ? 64'h1 : 64'h0);
        wr(8'h04, 32'h1, 4'b0001);
        step(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, '0);
        chk("irq_cleared", 64'(drop_irq), 64'h0);
        rd(8'h04);

        // Clearing read coincident with an increment
        for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 4'b0001);
        step(1'b1, 1'b0, 8'h18, 32'h0, 4'h0, 4'b0001);
        chk("cnt_preinc", 64'(last_rd), HAS_CNT ? 64'd7 : 64'd0);
        rd(8'h18);
        chk("cnt_after_clr", 64'(last_rd), HAS_CNT ? 64'd1 : 64'd0);

        // Disabled channel ignores pulses; out-of-range channel space is inert
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, 4'b0010);
        rd(8'h28);
        chk("ch1_disabled_cnt", 64'(last_rd), 64'd0);
        wr(8'hF0, 32'hFFFFFFFF, 4'b1111);
        rd(8'hF0);
        chk("unmapped_rd", 64'(last_rd), 64'd0);
        rd(8'h54);
        chk("ch4_absent", 64'(last_rd), 64'd0);

        // Random traffic against the model
        for (int i = 0; i < 600; i++) begin
            logic [7:0] a;
            if ($urandom_range(0, 9) == 0) a = 8'($urandom_range(0, 255));
            else a = addr_tbl[$urandom_range(0, 13)];
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0), a,
                 $urandom, 4'($urandom_range(0, 15)), NCH'($urandom_range(0, 15)));
        end

        // Reset while a read is in flight, then confirm defaults again
        step(1'b0, 1'b0, 8'h00, 32'h0, 4'h0, '0);
        do_reset();
        rd(8'h14);
        rd(8'h00);
        rd(8'h04);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
